// File: rtl/id_fwd_scoreboard_if.sv
// Bundle of decode-stage operand, forwarding and long-latency scoreboard signals.
// The master drives the decode/forwarding inputs. The slave is the scoreboard itself.
interface id_fwd_scoreboard_if #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NFWD = 2,
    parameter int CW   = 16
);
    logic                 id_valid;
    logic                 rs_read;
    logic                 rt_read;
    logic [AW-1:0]        rs_addr;
    logic [AW-1:0]        rt_addr;
    logic [DW-1:0]        rf_rs_data;
    logic [DW-1:0]        rf_rt_data;
    logic                 id_wreg;
    logic [AW-1:0]        id_wd;
    logic                 lat_issue;
    logic [NFWD-1:0]      fwd_wreg;
    logic [NFWD*AW-1:0]   fwd_waddr;
    logic [NFWD*DW-1:0]   fwd_wdata;
    logic [NFWD-1:0]      fwd_ready;
    logic                 lat_done;
    logic [AW-1:0]        lat_done_addr;
    logic                 flush;
    logic [DW-1:0]        rs_val;
    logic [DW-1:0]        rt_val;
    logic                 stallreq;
    logic [AW:0]          pend_cnt;
    logic [CW-1:0]        stall_cnt;

    modport master (
        output id_valid, rs_read, rt_read, rs_addr, rt_addr, rf_rs_data, rf_rt_data,
               id_wreg, id_wd, lat_issue, fwd_wreg, fwd_waddr, fwd_wdata, fwd_ready,
               lat_done, lat_done_addr, flush,
        input  rs_val, rt_val, stallreq, pend_cnt, stall_cnt
    );

    modport slave (
        input  id_valid, rs_read, rt_read, rs_addr, rt_addr, rf_rs_data, rf_rt_data,
               id_wreg, id_wd, lat_issue, fwd_wreg, fwd_waddr, fwd_wdata, fwd_ready,
               lat_done, lat_done_addr, flush,
        output rs_val, rt_val, stallreq, pend_cnt, stall_cnt
    );
endinterface

// File: rtl/id_fwd_scoreboard.sv
// Decode-stage operand forwarding with load-use detection and a pending-register scoreboard.
// The scoreboard tracks long-latency ops, raises stallreq, and keeps a saturating stall count.
module id_fwd_scoreboard #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NFWD = 2,
    parameter int CW   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    id_fwd_scoreboard_if.slave     bus
);
    localparam int NREG = 1 << AW;

    typedef enum logic {RUN, HOLD} state_t;

    typedef struct packed {
        logic          haz;
        logic [DW-1:0] val;
    } port_res_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [NREG-1:0] r_pend;
    logic [NREG-1:0] w_pend_next;
    logic [AW:0]     r_pend_cnt;
    logic [CW-1:0]   r_stall_cnt;
    port_res_t       w_rs;
    port_res_t       w_rt;
    logic            w_waw_haz;
    logic            w_stall;
    logic            w_issue;

    // The youngest matching source wins. If it is not ready, the port stalls rather than using an older match.
    function automatic port_res_t resolve(input logic rd, input logic [AW-1:0] addr,
                                          input logic [DW-1:0] rf);
        port_res_t res;
        logic      hit;
        res.haz = 1'b0;
        res.val = '0;
        hit     = 1'b0;
        if (rd && addr != '0) begin
            res.val = rf;
            for (int k = 0; k < NFWD; k++) begin
                if (!hit && bus.fwd_wreg[k] && bus.fwd_waddr[k*AW +: AW] == addr) begin
                    hit     = 1'b1;
                    res.val = bus.fwd_wdata[k*DW +: DW];
                    res.haz = !bus.fwd_ready[k];
                end
            end
            if (r_pend[addr] && !(bus.lat_done && bus.lat_done_addr == addr))
                res.haz = 1'b1;
        end
        return res;
    endfunction

    function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
        logic [AW:0] n;
        n = '0;
        for (int i = 0; i < NREG; i++)
            n = n + {{AW{1'b0}}, v[i]};
        return n;
    endfunction

    always_comb begin
        w_rs      = resolve(bus.rs_read, bus.rs_addr, bus.rf_rs_data);
        w_rt      = resolve(bus.rt_read, bus.rt_addr, bus.rf_rt_data);
        w_waw_haz = bus.id_wreg && r_pend[bus.id_wd] &&
                    !(bus.lat_done && bus.lat_done_addr == bus.id_wd);
        w_stall   = !rst && bus.id_valid && !bus.flush && (w_rs.haz || w_rt.haz || w_waw_haz);
        w_issue   = bus.id_valid && bus.lat_issue && !w_stall && !bus.flush && bus.id_wd != '0;
    end

    // A new issue is applied after the writeback clear, so it wins when both hit the same register.
    always_comb begin
        w_pend_next = r_pend;
        if (bus.lat_done)
            w_pend_next[bus.lat_done_addr] = 1'b0;
        if (w_issue)
            w_pend_next[bus.id_wd] = 1'b1;
        w_pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend      <= '0;
            r_pend_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_pend     <= w_pend_next;
            r_pend_cnt <= popcount(w_pend_next);
            if (w_stall && r_stall_cnt != {CW{1'b1}})
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= RUN;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:     if (w_stall)  w_state_next = HOLD;
            HOLD:    if (!w_stall) w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

    assign bus.rs_val    = rst ? '0 : w_rs.val;
    assign bus.rt_val    = rst ? '0 : w_rt.val;
    assign bus.stallreq  = w_stall;
    assign bus.pend_cnt  = r_pend_cnt;
    assign bus.stall_cnt = r_stall_cnt;
endmodule
